// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU arbiter slice.
//   - ALU op codes driven onto alu_op
//   - FSM state encoding of the arbiter
//   - default datapath width
package alu_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_SHIFT = 2'b10;
  localparam logic [1:0] ALU_AND   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // One-hot vector for a requester index (0 or 1).
  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between the two requesters and
// the ALU arbiter.
//
// Handshake semantics (both channels, per requester bit i):
//   A transfer happens on a rising clk edge where valid[i] && ready[i].
//   valid must not depend on ready; the payload (op/a/b on the request
//   channel) is held stable by the source while valid is high and not yet
//   accepted. rsp_data is shared by both ports and is only meaningful for
//   the bit of rsp_valid that is set.
//
// Modports:
//   master - requester side (drives requests, accepts responses)
//   slave  - arbiter side
interface alu_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_op0;
  logic [1:0]       req_op1;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant, purely combinational.
//   req[1:0]   in   request vector
//   last       in   index of the most recently granted requester
//   grant[1:0] out  one-hot grant (all zero when nothing is requested)
// On contention the requester that was not served last wins, so neither
// side waits more than one operation.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters
// (port 0 = execute unit, port 1 = address/PC unit).
//
// Ports:
//   clk, rst_n      clock (rising edge), async active-low reset
//   bus             alu_arbiter_if.slave: req_valid/req_ready/op/a/b in,
//                   rsp_valid/rsp_ready/rsp_data out
//   alu_a, alu_b    registered operands to the external ALU
//   alu_op          registered op code to the external ALU
//   alu_res         combinational result from the external ALU
//   busy            high whenever the FSM is not in IDLE
//   dbg_state       current FSM state
//
// Flow: IDLE grants one requester and latches its op/operands; EXEC gives
// the ALU one cycle to settle and captures the result; RESP presents the
// result to the issuing requester until it accepts.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_res,
  output logic             busy,
  output state_t           dbg_state
);

  state_t           state, state_nxt;
  logic             last;      // most recently granted requester
  logic             id;        // owner of the operation in flight
  logic [WIDTH-1:0] res_q;
  logic [1:0]       grant;
  logic             accept;
  logic             gsel;      // index of the granted requester

  rr_arb2 u_rr_arb2 (
    .req   (bus.req_valid),
    .last  (last),
    .grant (grant)
  );

  // grant is only non-zero for a valid requester, so any grant in IDLE is
  // a completed request handshake.
  assign accept = (state == ST_IDLE) && (grant != 2'b00);
  assign gsel   = grant[1];

  // Next state and handshake outputs.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    unique case (state)
      ST_IDLE: begin
        bus.req_ready = grant;
        if (accept) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = port_onehot(id);
        // Only the owner's rsp_ready bit completes the response.
        if (bus.rsp_ready[id]) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers. alu_* only change on acceptance so the ALU inputs
  // never glitch between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last   <= 1'b1;
      id     <= 1'b0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= ALU_ADD;
      res_q  <= '0;
    end else begin
      if (accept) begin
        id     <= gsel;
        last   <= gsel;
        alu_op <= gsel ? bus.req_op1 : bus.req_op0;
        alu_a  <= gsel ? bus.req_a1  : bus.req_a0;
        alu_b  <= gsel ? bus.req_b1  : bus.req_b0;
      end
      if (state == ST_EXEC) begin
        res_q <= alu_res;
      end
    end
  end

  assign bus.rsp_data = res_q;
  assign busy         = (state != ST_IDLE);
  assign dbg_state    = state;

endmodule
